// File: rtl/cntr_updn_modulus_la_pkg.sv
// Shared definitions for the up/down modulus counter family: direction codes,
// a ceil-log2 helper and the modulus legality check used at elaboration.
package cntr_updn_modulus_la_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Number of bits needed to represent value-1 (0 for value <= 1).
    function automatic int cntr_clog2(input longint value);
        int bits;
        bits = 0;
        for (int i = 0; i < 63; i++) begin
            if ((longint'(1) << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

    // A modulus is usable when it has at least two states and fits in width bits.
    function automatic bit mod_val_legal(input int width, input longint mod_val);
        return (width >= 1) && (width <= 62) && (mod_val >= 2) &&
               (cntr_clog2(mod_val) <= width);
    endfunction

endpackage

// File: rtl/cntr_mod_next.sv
// Next-state logic of the up/down modulus counter: next value, next lookahead
// flags and the wrap/clamp events, all purely combinational.
module cntr_mod_next
    import cntr_updn_modulus_la_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MOD_VAL  = 67,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic             at_max,
    input  logic             at_zero,
    input  logic             ena,
    input  logic             sclear,
    input  logic             sload,
    input  logic [WIDTH-1:0] sdata,
    input  logic             inc_not_dec,
    output logic [WIDTH-1:0] next_q,
    output logic             next_at_max,
    output logic             next_at_zero,
    output logic             wrap_evt,
    output logic             clamp_evt
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD_VAL - 1);

    always_comb begin
        next_q       = q;
        next_at_max  = at_max;
        next_at_zero = at_zero;
        wrap_evt     = 1'b0;
        clamp_evt    = 1'b0;
        if (ena) begin
            if (sclear) begin
                next_q = '0;
            end else if (sload) begin
                if (sdata > MAX_Q) begin
                    next_q    = MAX_Q;
                    clamp_evt = 1'b1;
                end else begin
                    next_q = sdata;
                end
            end else if (inc_not_dec == CNT_UP) begin
                // Terminal detection uses the registered flags, not a compare on q.
                if (at_max) begin
                    wrap_evt = 1'b1;
                    next_q   = (SATURATE != 0) ? q : '0;
                end else begin
                    next_q = q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    wrap_evt = 1'b1;
                    next_q   = (SATURATE != 0) ? q : MAX_Q;
                end else begin
                    next_q = q - 1'b1;
                end
            end
            next_at_max  = (next_q == MAX_Q);
            next_at_zero = (next_q == '0);
        end
    end

endmodule

// File: rtl/cntr_updn_modulus_la.sv
// Up/down modulus counter with clamped load, wrap/saturate selection and a
// registered lookahead terminal flag feeding a combinational cascade output.
module cntr_updn_modulus_la
    import cntr_updn_modulus_la_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MOD_VAL  = 67,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             sclear,
    input  logic             sload,
    input  logic [WIDTH-1:0] sdata,
    input  logic             inc_not_dec,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_clamped
);

    if (!mod_val_legal(WIDTH, MOD_VAL)) begin : g_bad_mod_val
        $error("cntr_updn_modulus_la: MOD_VAL must lie in 2..2**WIDTH");
    end

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] next_q;
    logic             next_at_max;
    logic             next_at_zero;
    logic             wrap_evt;
    logic             clamp_evt;

    cntr_mod_next #(
        .WIDTH    (WIDTH),
        .MOD_VAL  (MOD_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .q            (q),
        .at_max       (at_max),
        .at_zero      (at_zero),
        .ena          (ena),
        .sclear       (sclear),
        .sload        (sload),
        .sdata        (sdata),
        .inc_not_dec  (inc_not_dec),
        .next_q       (next_q),
        .next_at_max  (next_at_max),
        .next_at_zero (next_at_zero),
        .wrap_evt     (wrap_evt),
        .clamp_evt    (clamp_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            q            <= '0;
            at_max       <= 1'b0;
            at_zero      <= 1'b1;
            wrap         <= 1'b0;
            load_clamped <= 1'b0;
        end else begin
            q            <= next_q;
            at_max       <= next_at_max;
            at_zero      <= next_at_zero;
            wrap         <= wrap_evt;
            load_clamped <= clamp_evt;
        end
    end

    // Cascade output: only flag selection and control gating, no compare on q.
    assign tc = ena & ~sclear & ~sload & (inc_not_dec ? at_max : at_zero);

endmodule

// File: tb/tb_cntr_updn_modulus_la.sv
// Scoreboard bench: three counter configurations share one stimulus bus;
// each directed step queues its expected post-edge response for the monitor.
module tb_cntr_updn_modulus_la;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       sclear = 1'b0;
    logic       sload = 1'b0;
    logic [7:0] sdata = 8'd0;
    logic       inc_not_dec = 1'b1;

    logic [7:0] q0, q1;
    logic [3:0] q2;
    logic       tc0, tc1, tc2, wrap0, wrap1, wrap2, lc0, lc1, lc2;

    always #5 clk = ~clk;

    cntr_updn_modulus_la #(.WIDTH(8), .MOD_VAL(67), .SATURATE(0)) d0 (
        .clk(clk), .rst(rst), .ena(ena), .sclear(sclear), .sload(sload),
        .sdata(sdata), .inc_not_dec(inc_not_dec),
        .q(q0), .tc(tc0), .wrap(wrap0), .load_clamped(lc0));

    cntr_updn_modulus_la #(.WIDTH(8), .MOD_VAL(67), .SATURATE(1)) d1 (
        .clk(clk), .rst(rst), .ena(ena), .sclear(sclear), .sload(sload),
        .sdata(sdata), .inc_not_dec(inc_not_dec),
        .q(q1), .tc(tc1), .wrap(wrap1), .load_clamped(lc1));

    cntr_updn_modulus_la #(.WIDTH(4), .MOD_VAL(16), .SATURATE(0)) d2 (
        .clk(clk), .rst(rst), .ena(ena), .sclear(sclear), .sload(sload),
        .sdata(sdata[3:0]), .inc_not_dec(inc_not_dec),
        .q(q2), .tc(tc2), .wrap(wrap2), .load_clamped(lc2));

    typedef struct {
        int         dut;
        logic [7:0] q;
        logic       wrap;
        logic       lc;
        logic       tc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor: outputs are sampled 1 ns after each rising edge.
    initial begin
        exp_t       e;
        logic [7:0] aq;
        logic       aw, al, at;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.dut)
                    0:       begin aq = q0;         aw = wrap0; al = lc0; at = tc0; end
                    1:       begin aq = q1;         aw = wrap1; al = lc1; at = tc1; end
                    default: begin aq = {4'd0, q2}; aw = wrap2; al = lc2; at = tc2; end
                endcase
                check({e.name, ".q"},    int'(aq), int'(e.q));
                check({e.name, ".wrap"}, int'(aw), int'(e.wrap));
                check({e.name, ".lc"},   int'(al), int'(e.lc));
                check({e.name, ".tc"},   int'(at), int'(e.tc));
            end
        end
    end

    // Drive one cycle of inputs and queue the response expected after the edge.
    task automatic step(input int dut, input logic r, input logic e, input logic sc,
                        input logic sl, input logic [7:0] sd, input logic up,
                        input logic [7:0] eq, input logic ew, input logic elc,
                        input logic etc, input string name);
        exp_t x;
        @(negedge clk);
        rst = r; ena = e; sclear = sc; sload = sl; sdata = sd; inc_not_dec = up;
        x.dut = dut; x.q = eq; x.wrap = ew; x.lc = elc; x.tc = etc; x.name = name;
        sb.push_back(x);
    endtask

    initial begin
        logic [7:0] seq2 [7];
        logic [7:0] eq;
        int         guard;
        seq2 = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd66, 8'd65};

        // 1. reset, then count up through a full period
        step(0, 1, 0, 0, 0, 8'd0, 1, 8'd0, 0, 0, 0, "reset");
        for (int i = 0; i < 67; i++) begin
            eq = (i == 66) ? 8'd0 : 8'(i + 1);
            step(0, 0, 1, 0, 0, 8'd0, 1, eq, i == 66, 0, i == 65, $sformatf("up%0d", i));
        end
        step(0, 0, 1, 0, 0, 8'd0, 1, 8'd1, 0, 0, 0, "up_after_wrap");

        // 2. load 5, count down through zero
        step(0, 0, 1, 0, 1, 8'd5, 0, 8'd5, 0, 0, 0, "load5");
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 0, 0, 8'd0, 0, seq2[i], i == 5, 0, i == 4, $sformatf("dn%0d", i));
        end

        // 3. clamped load and boundary loads
        step(0, 0, 1, 0, 1, 8'd200, 1, 8'd66, 0, 1, 0, "load200");
        step(0, 0, 1, 0, 0, 8'd0, 1, 8'd0, 1, 0, 0, "up_from_clamp");
        step(0, 0, 1, 0, 1, 8'd66, 1, 8'd66, 0, 0, 0, "load66");
        step(0, 0, 1, 0, 1, 8'd67, 1, 8'd66, 0, 1, 0, "load67");
        step(0, 0, 1, 0, 0, 8'd0, 0, 8'd65, 0, 0, 0, "dn_from_66");

        // 4. saturating configuration
        step(1, 0, 1, 0, 1, 8'd65, 1, 8'd65, 0, 0, 0, "sat_load65");
        step(1, 0, 1, 0, 0, 8'd0, 1, 8'd66, 0, 0, 1, "sat_up0");
        step(1, 0, 1, 0, 0, 8'd0, 1, 8'd66, 1, 0, 1, "sat_up1");
        step(1, 0, 1, 0, 0, 8'd0, 1, 8'd66, 1, 0, 1, "sat_up2");
        step(1, 0, 1, 0, 1, 8'd1, 0, 8'd1, 0, 0, 0, "sat_load1");
        step(1, 0, 1, 0, 0, 8'd0, 0, 8'd0, 0, 0, 1, "sat_dn0");
        step(1, 0, 1, 0, 0, 8'd0, 0, 8'd0, 1, 0, 1, "sat_dn1");
        step(1, 0, 1, 0, 0, 8'd0, 0, 8'd0, 1, 0, 1, "sat_dn2");

        // 5. control priority and reset during load
        step(0, 0, 1, 0, 1, 8'd30, 1, 8'd30, 0, 0, 0, "load30");
        step(0, 0, 1, 1, 1, 8'd10, 1, 8'd0, 0, 0, 0, "clr_over_load");
        step(0, 0, 1, 0, 1, 8'd20, 1, 8'd20, 0, 0, 0, "load20");
        step(0, 0, 0, 1, 0, 8'd0, 1, 8'd20, 0, 0, 0, "clr_no_ena");
        step(0, 0, 0, 0, 1, 8'd200, 1, 8'd20, 0, 0, 0, "load_no_ena");
        step(0, 0, 1, 0, 1, 8'd200, 1, 8'd66, 0, 1, 0, "load_clamp_again");
        step(0, 1, 1, 0, 1, 8'd200, 1, 8'd0, 0, 0, 0, "rst_over_load");
        step(0, 0, 1, 0, 0, 8'd0, 0, 8'd66, 1, 0, 0, "dn_after_rst");
        step(0, 0, 0, 0, 0, 8'd0, 0, 8'd66, 0, 0, 0, "hold_drops_wrap");
        step(0, 0, 1, 0, 0, 8'd0, 1, 8'd0, 1, 0, 0, "up_wrap_again");

        // 6. full binary modulus
        step(2, 0, 1, 0, 1, 8'd15, 1, 8'd15, 0, 0, 0, "w4_load15");
        step(2, 0, 1, 0, 0, 8'd0, 1, 8'd0, 1, 0, 0, "w4_up_roll");
        step(2, 0, 1, 0, 0, 8'd0, 0, 8'd15, 1, 0, 0, "w4_dn_roll");
        step(2, 0, 1, 0, 0, 8'd0, 0, 8'd14, 0, 0, 0, "w4_dn");

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
